apb_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single APB master command interface between NREQ local requesters. It drives transfer, READ_WRITE, APB_WRITE_DATA, APB_WRITE_PADDR and APB_READ_PADDR into the APB master. It then watches the master's bus-side PSEL/PENABLE/PREADY to detect completion and returns read data and error status to the granted requester. It sits between the block-level initiators and the APB master, one transaction outstanding at a time.

---
 rtl/apb_req_arbiter_if.sv | 59 +++++
 rtl/apb_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter_if
//
// Bundles every signal between the round-robin APB request arbiter and its
// surroundings: the NREQ local requesters on one side, and the APB master
// command inputs plus the observed bus/slave response on the other.
//
// Modports
//   master : the arbiter itself. It masters the shared APB command interface,
//            so it takes requests and bus responses and drives grants,
//            completion pulses and the APB master command signals.
//   slave  : the environment (requesters + APB master/slave), mirror image.
//
// Signals
//   req/req_rw/req_addr/req_wdata   requester inputs, requester i packed at
//                                   [i*AW +: AW] / [i*DW +: DW]
//   gnt/done/rsp_rdata/rsp_err      per-requester grant, completion pulse,
//                                   read data and error returned with done
//   transfer/READ_WRITE/APB_*       command into the APB master
//   PSEL/PENABLE/PREADY/PSLVERR/PRDATA  bus-side observation and response
// ----------------------------------------------------------------------------
interface apb_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               transfer;
  logic               READ_WRITE;
  logic [DW-1:0]      APB_WRITE_DATA;
  logic [AW-1:0]      APB_WRITE_PADDR;
  logic [AW-1:0]      APB_READ_PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PREADY;
  logic               PSLVERR;
  logic [DW-1:0]      PRDATA;

  modport master (
    input  req, req_rw, req_addr, req_wdata,
    input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    output gnt, done, rsp_rdata, rsp_err,
    output transfer, READ_WRITE, APB_WRITE_DATA, APB_WRITE_PADDR, APB_READ_PADDR
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata,
    output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    input  gnt, done, rsp_rdata, rsp_err,
    input  transfer, READ_WRITE, APB_WRITE_DATA, APB_WRITE_PADDR, APB_READ_PADDR
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter sharing one APB master command interface between NREQ
// requesters, one transaction outstanding at a time. A winner is picked in
// IDLE, its direction/address/data are latched and presented to the APB
// master during XFER, completion (PSEL & PENABLE & PREADY) is watched on the
// bus, and a one-cycle done pulse with read data / error goes back in DONE.
//
// Ports
//   PCLK    clock, all logic on the rising edge
//   PRESET  synchronous active-high reset; aborts any transaction, no done
//   bus     apb_req_arbiter_if.master (requesters, APB command, bus status)
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   When defined, an XFER that sees no completion for TIMEOUT_CYC cycles is
//   ended with rsp_err=1 and rsp_rdata=0. When undefined, XFER waits forever.
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] pick;
  logic            rw_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            complete;
  logic            timeout;
  logic [NREQ-1:0] owner_oh;

  // First requester with req high, scanning upward from the pointer with
  // wrap. Scanning offsets from high to low lets the smallest offset win.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] p);
    logic [IDXW-1:0] w;
    logic [IDXW-1:0] jj;
    int              j;
    w = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j  = (int'(p) + k) % NREQ;
      jj = IDXW'(j);
      if (r[jj]) w = jj;
    end
    return w;
  endfunction

  // Pointer advance that wraps at NREQ-1 even when NREQ is not a power of 2.
  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] i);
    return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign pick     = rr_pick(bus.req, ptr_q);
  assign complete = bus.PSEL & bus.PENABLE & bus.PREADY;
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
  logic [CNTW-1:0] cnt_q;

  // cnt_q holds the number of XFER cycles already spent without completion,
  // so the last allowed cycle is the one where it equals TIMEOUT_CYC-1.
  assign timeout = (cnt_q == CNTW'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (state_q == XFER) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Control state: the only registers that see reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DONE) ptr_q <= rr_next(idx_q);
    end
  end

  // Transaction data: latched at grant and at completion, never reset.
  // Everything here reaches the outputs only through state-gated muxes.
  always_ff @(posedge PCLK) begin
    if (state_q == IDLE && |bus.req) begin
      idx_q   <= pick;
      rw_q    <= bus.req_rw[pick];
      addr_q  <= bus.req_addr[pick*AW +: AW];
      wdata_q <= bus.req_wdata[pick*DW +: DW];
    end
    if (state_q == XFER) begin
      if (complete) begin
        rdata_q <= rw_q ? '0 : bus.PRDATA;
        err_q   <= bus.PSLVERR;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Next state and outputs. Outputs depend only on registered state, so
  // grant/transfer appear one cycle after the winning request is sampled.
  always_comb begin
    state_d             = state_q;
    bus.gnt             = '0;
    bus.done            = '0;
    bus.rsp_rdata       = '0;
    bus.rsp_err         = 1'b0;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.APB_WRITE_DATA  = '0;
    bus.APB_WRITE_PADDR = '0;
    bus.APB_READ_PADDR  = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = XFER;
      end
      XFER: begin
        bus.transfer   = 1'b1;
        bus.gnt        = owner_oh;
        bus.READ_WRITE = rw_q;
        if (rw_q) begin
          bus.APB_WRITE_PADDR = addr_q;
          bus.APB_WRITE_DATA  = wdata_q;
        end else begin
          bus.APB_READ_PADDR  = addr_q;
        end
        if (complete || timeout) state_d = DONE;
      end
      DONE: begin
        bus.done      = owner_oh;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Bench for apb_req_arbiter (NREQ=4, AW=8, DW=8, TIMEOUT_CYC=16). A
// transaction-level model tracks owner, pending done, pointer and latched
// command; every cycle the DUT outputs are compared with what that model
// implies. Directed sequences pin the model with literal expectations, then
// random requesters and a random bus exercise the arbiter.
// ----------------------------------------------------------------------------
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int            m_own = -1;  // requester currently being served
  int            m_fin = -1;  // requester whose done pulse is this cycle
  int            m_ptr = 0;
  int            m_xc  = 0;   // XFER cycles elapsed for current owner
  int            m_i;
  logic          m_lrw;
  logic [AW-1:0] m_laddr;
  logic [DW-1:0] m_lwdata;
  logic [DW-1:0] m_frd;
  logic          m_ferr;

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_own = -1;
      m_fin = -1;
      m_ptr = 0;
    end else if (m_fin >= 0) begin
      m_ptr = (m_fin + 1) % NREQ;
      m_fin = -1;
    end else if (m_own >= 0) begin
      m_xc++;
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        m_fin  = m_own;
        m_ferr = bus.PSLVERR;
        m_frd  = m_lrw ? 8'h00 : bus.PRDATA;
        m_own  = -1;
      end
`ifdef APB_ARB_TIMEOUT_EN
      else if (m_xc >= TMO) begin
        m_fin  = m_own;
        m_ferr = 1'b1;
        m_frd  = 8'h00;
        m_own  = -1;
      end
`endif
    end else if (bus.req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_ptr + k) % NREQ;
        if (m_own < 0 && bus.req[m_i[1:0]]) m_own = m_i;
      end
      m_lrw    = bus.req_rw[m_own[1:0]];
      m_laddr  = bus.req_addr[m_own*AW +: AW];
      m_lwdata = bus.req_wdata[m_own*DW +: DW];
      m_xc     = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NREQ-1:0] e_gnt, e_done;
  always @(negedge PCLK) begin
    if (chk_en) begin
      e_gnt  = '0;
      e_done = '0;
      if (m_own >= 0) e_gnt[m_own[1:0]] = 1'b1;
      if (m_fin >= 0) e_done[m_fin[1:0]] = 1'b1;
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
      chk("transfer", 32'(bus.transfer), 32'(m_own >= 0));
      chk("read_write", 32'(bus.READ_WRITE), 32'(m_own >= 0 && m_lrw));
      chk("wr_paddr", 32'(bus.APB_WRITE_PADDR), (m_own >= 0 && m_lrw) ? 32'(m_laddr) : 0);
      chk("wr_data", 32'(bus.APB_WRITE_DATA), (m_own >= 0 && m_lrw) ? 32'(m_lwdata) : 0);
      chk("rd_paddr", 32'(bus.APB_READ_PADDR), (m_own >= 0 && !m_lrw) ? 32'(m_laddr) : 0);
      chk("rsp_rdata", 32'(bus.rsp_rdata), (m_fin >= 0) ? 32'(m_frd) : 0);
      chk("rsp_err", 32'(bus.rsp_err), (m_fin >= 0) ? 32'(m_ferr) : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic apb_set(input logic sel, input logic en, input logic rdy,
                         input logic err, input logic [DW-1:0] rd);
    bus.PSEL    = sel;
    bus.PENABLE = en;
    bus.PREADY  = rdy;
    bus.PSLVERR = err;
    bus.PRDATA  = rd;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i[1:0]]            = v;
    bus.req_rw[i[1:0]]         = rw;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  int grants[$];
  int exp_ord[4] = '{0, 3, 0, 3};

  initial begin
    logic [NREQ-1:0] prev_g;
    int ndone, idle_run, gcyc, dseen;
    bit seen_done;

    PRESET        = 1'b1;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    apb_set(0, 0, 0, 0, 0);
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_transfer", 32'(bus.transfer), 0);
    chk("rst_done", 32'(bus.done), 0);
    PRESET = 1'b0;

    // Write by requester 1, setup phase with PREADY high must not complete.
    set_req(1, 1, 1, 8'h01, 8'hAA);
    step();
    chk("wr_gnt", 32'(bus.gnt), 2);
    chk("wr_rw", 32'(bus.READ_WRITE), 1);
    chk("wr_paddr_lit", 32'(bus.APB_WRITE_PADDR), 32'h01);
    chk("wr_wdata_lit", 32'(bus.APB_WRITE_DATA), 32'hAA);
    chk("wr_rpaddr_lit", 32'(bus.APB_READ_PADDR), 0);
    apb_set(1, 0, 1, 0, 0);
    step();
    chk("wr_setup_nodone", 32'(bus.done), 0);
    apb_set(1, 1, 1, 0, 0);
    step();
    chk("wr_done", 32'(bus.done), 2);
    chk("wr_err", 32'(bus.rsp_err), 0);
    set_req(1, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
    chk("wr_done_clear", 32'(bus.done), 0);

    // Read by requester 2 with one wait state.
    set_req(2, 1, 0, 8'h01, 8'h00);
    step();
    chk("rd_gnt", 32'(bus.gnt), 4);
    chk("rd_rpaddr_lit", 32'(bus.APB_READ_PADDR), 32'h01);
    chk("rd_rw", 32'(bus.READ_WRITE), 0);
    apb_set(1, 1, 0, 0, 8'h5A);
    step();
    chk("rd_wait_nodone", 32'(bus.done), 0);
    apb_set(1, 1, 1, 0, 8'h5A);
    step();
    chk("rd_done", 32'(bus.done), 4);
    chk("rd_rdata_lit", 32'(bus.rsp_rdata), 32'h5A);
    set_req(2, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
    chk("rd_rdata_clear", 32'(bus.rsp_rdata), 0);

    // Slave error on a write by requester 0, then a clean read.
    set_req(0, 1, 1, 8'h10, 8'h33);
    step();
    apb_set(1, 1, 1, 1, 0);
    step();
    chk("err_done", 32'(bus.done), 1);
    chk("err_flag", 32'(bus.rsp_err), 1);
    set_req(0, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
    set_req(1, 1, 0, 8'h02, 8'h00);
    step();
    apb_set(1, 1, 1, 0, 8'h77);
    step();
    chk("nxt_done", 32'(bus.done), 2);
    chk("nxt_err", 32'(bus.rsp_err), 0);
    chk("nxt_rdata", 32'(bus.rsp_rdata), 32'h77);
    set_req(1, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();

    // Reset in the middle of a transfer.
    set_req(2, 1, 1, 8'h20, 8'h44);
    step();
    chk("rst_pre_gnt", 32'(bus.gnt), 4);
    apb_set(1, 1, 0, 0, 0);
    PRESET = 1'b1;
    step();
    chk("rst_mid_transfer", 32'(bus.transfer), 0);
    chk("rst_mid_gnt", 32'(bus.gnt), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    PRESET = 1'b0;
    set_req(2, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
    chk("rst_after_done", 32'(bus.done), 0);

    // Contention between 0 and 3, both held; bus completes immediately.
    set_req(0, 1, 0, 8'h30, 8'h00);
    set_req(3, 1, 0, 8'h33, 8'h00);
    apb_set(1, 1, 1, 0, 8'hC3);
    prev_g = '0; ndone = 0; idle_run = 0; seen_done = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      step();
      if (bus.gnt != 0 && prev_g == 0) begin
        grants.push_back(oh_idx(bus.gnt));
        if (seen_done) chk("cont_gap", 32'(idle_run), 1);
      end
      if (bus.done != 0) begin
        ndone++;
        seen_done = 1;
        idle_run  = 0;
      end else if (bus.gnt == 0) begin
        idle_run++;
      end
      prev_g = bus.gnt;
    end
    set_req(0, 0, 0, 0, 0);
    set_req(3, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    chk("cont_ndone", 32'(ndone), 4);
    chk("cont_ngrants", 32'(grants.size()), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("cont_order", 32'(grants[k]), 32'(exp_ord[k]));
    step();
    step();

    // Slave never ready.
    set_req(1, 1, 0, 8'h44, 8'h00);
    apb_set(1, 1, 0, 0, 0);
    step();
    gcyc = 0; dseen = 0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int c = 0; c < 40 && dseen == 0; c++) begin
      if (bus.gnt == 2) gcyc++;
      if (bus.done != 0) begin
        dseen = 1;
        chk("tmo_done", 32'(bus.done), 2);
        chk("tmo_err", 32'(bus.rsp_err), 1);
        chk("tmo_rdata", 32'(bus.rsp_rdata), 0);
      end else begin
        step();
      end
    end
    chk("tmo_cycles", 32'(gcyc), TMO);
    chk("tmo_seen", 32'(dseen), 1);
    set_req(1, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
`else
    for (int c = 0; c < 40; c++) begin
      if (bus.gnt == 2) gcyc++;
      if (bus.done != 0) dseen++;
      step();
    end
    chk("stuck_gnt_cycles", 32'(gcyc), 40);
    chk("stuck_nodone", 32'(dseen), 0);
    apb_set(1, 1, 1, 0, 8'h99);
    step();
    chk("stuck_release_done", 32'(bus.done), 2);
    chk("stuck_release_rdata", 32'(bus.rsp_rdata), 32'h99);
    set_req(1, 0, 0, 0, 0);
    apb_set(0, 0, 0, 0, 0);
    step();
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.done[i[1:0]]) begin
          if ($urandom_range(2, 0) == 0) bus.req[i[1:0]] = 1'b0;
          else set_req(i, 1, 1'($urandom), AW'($urandom), DW'($urandom));
        end else if (!bus.req[i[1:0]]) begin
          if ($urandom_range(3, 0) == 0) set_req(i, 1, 1'($urandom), AW'($urandom), DW'($urandom));
        end else if ($urandom_range(63, 0) == 0) begin
          bus.req[i[1:0]] = 1'b0;
        end else if ($urandom_range(15, 0) == 0) begin
          set_req(i, 1, 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
      apb_set($urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom),
              $urandom_range(3, 0) == 0, DW'($urandom));
      PRESET = ($urandom_range(399, 0) == 0);
      step();
    end

    PRESET  = 1'b0;
    bus.req = '0;
    apb_set(1, 1, 1, 0, 0);
    repeat (20) step();
    chk("final_idle_gnt", 32'(bus.gnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
